// File: rtl/checker_memory_pkg.sv
// Shared defaults, helpers and FSM type for the banked checker memory.
// Option: CHECKER_MEMORY_BANKED_MPU_OREG_EN registers the MPU rotator output.
package checker_memory_pkg;

  localparam int LANES_DEF     = 8;
  localparam int ROWS_DEF      = 4096;
  localparam int MPU_BYTES_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    ACK
  } wb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/checker_memory_lane.sv
// One byte-wide lane of the banked checker memory.
// Port A: Wishbone read/write. Port B: read-first MPU read.
module checker_memory_lane
  import checker_memory_pkg::*;
#(
  parameter int ROWS = ROWS_DEF
) (
  input  logic                   sys_clk,
  input  logic [clog2(ROWS)-1:0] addr_a,
  input  logic                   we_a,
  input  logic [7:0]             din_a,
  output logic [7:0]             dout_a,
  input  logic                   en_b,
  input  logic [clog2(ROWS)-1:0] addr_b,
  output logic [7:0]             dout_b
);

  logic [7:0] ram [ROWS];

  always_ff @(posedge sys_clk) begin
    if (we_a) ram[addr_a] <= din_a;
    dout_a <= ram[addr_a];
  end

  // Non-blocking read returns the pre-write byte on a same-cycle collision
  always_ff @(posedge sys_clk) begin
    if (en_b) dout_b <= ram[addr_b];
  end

endmodule

// File: rtl/checker_memory_banked.sv
// Byte-lane banked memory: Wishbone load/read-back plus unaligned MPU fetch.
// Option: CHECKER_MEMORY_BANKED_MPU_OREG_EN adds an MPU output register.
module checker_memory_banked
  import checker_memory_pkg::*;
#(
  parameter int  LANES     = LANES_DEF,
  parameter int  ROWS      = ROWS_DEF,
  parameter int  MPU_BYTES = MPU_BYTES_DEF,
  localparam int AW        = clog2(LANES * ROWS)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   mpu_en,
  input  logic [AW-1:0]          mpu_addr,
  output logic [8*MPU_BYTES-1:0] mpu_do,
  output logic                   mpu_valid,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_we_i,
  output logic                   wb_ack_o
);

  localparam int LW = clog2(LANES);
  localparam int RW = clog2(ROWS);

  wb_state_t        state, state_nxt;
  logic             wb_req, wb_wr, wb_rd;
  logic [RW-1:0]    wb_row;
  logic [LW-1:0]    wb_base, rd_base;
  logic [LW-1:0]    mpu_off, off_q;
  logic [RW-1:0]    mpu_row;
  logic             v_q;
  logic [LANES-1:0] a_we;
  logic [7:0]       a_dout [LANES];
  logic [7:0]       b_dout [LANES];
  logic [RW-1:0]    b_row  [LANES];
  logic [8*MPU_BYTES-1:0] rot;
  logic             unused;

  assign unused  = ^{wb_adr_i[31:AW], wb_adr_i[1:0]};
  assign wb_req  = wb_cyc_i & wb_stb_i;
  assign wb_row  = wb_adr_i[AW-1:LW];
  assign wb_base = wb_adr_i[LW-1:0] & ~LW'(3);
  assign mpu_off = mpu_addr[LW-1:0];
  assign mpu_row = mpu_addr[AW-1:LW];

  always_comb begin
    state_nxt = state;
    wb_wr     = 1'b0;
    wb_rd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb_req) begin
          wb_wr     = wb_we_i;
          wb_rd     = ~wb_we_i;
          state_nxt = wb_we_i ? ACK : RD;
        end
      end
      RD:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      rd_base  <= '0;
      wb_dat_o <= '0;
    end else begin
      state <= state_nxt;
      if (wb_rd) rd_base <= wb_base;
      if (state == RD) begin
        for (int k = 0; k < 4; k++) begin
          wb_dat_o[8*k+:8] <= a_dout[rd_base | LW'(k)];
        end
      end
    end
  end

  assign wb_ack_o = (state == ACK);

  // Lanes below the offset belong to the following (wrapping) row
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign a_we[i]  = wb_wr
                    && ((LW'(i) & ~LW'(3)) == wb_base)
                    && wb_sel_i[i%4];
    assign b_row[i] = (LW'(i) < mpu_off) ? mpu_row + RW'(1) : mpu_row;

    checker_memory_lane #(
      .ROWS(ROWS)
    ) u_lane (
      .sys_clk(sys_clk),
      .addr_a (wb_row),
      .we_a   (a_we[i]),
      .din_a  (wb_dat_i[8*(i%4)+:8]),
      .dout_a (a_dout[i]),
      .en_b   (mpu_en),
      .addr_b (b_row[i]),
      .dout_b (b_dout[i])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_q   <= 1'b0;
      off_q <= '0;
    end else begin
      v_q <= mpu_en;
      if (mpu_en) off_q <= mpu_off;
    end
  end

  always_comb begin
    logic [LW-1:0] idx;
    rot = '0;
    idx = '0;
    for (int k = 0; k < MPU_BYTES; k++) begin
      idx = off_q + LW'(k);
      rot[8*k+:8] = b_dout[idx];
    end
  end

`ifdef CHECKER_MEMORY_BANKED_MPU_OREG_EN
  logic                   v2_q;
  logic [8*MPU_BYTES-1:0] do_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v2_q <= 1'b0;
      do_q <= '0;
    end else begin
      v2_q <= v_q;
      do_q <= v_q ? rot : '0;
    end
  end

  assign mpu_valid = v2_q;
  assign mpu_do    = do_q;
`else
  assign mpu_valid = v_q;
  assign mpu_do    = v_q ? rot : '0;
`endif

endmodule
